// File: rtl/spi_boot_pkg.sv
// Shared types and helpers for the SPI flash boot loader.
package spi_boot_pkg;

    // Boot sequencer states
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CMD   = 4'd1,
        ST_CWAIT = 4'd2,
        ST_XFER  = 4'd3,
        ST_XWAIT = 4'd4,
        ST_RD    = 4'd5,
        ST_MWR   = 4'd6,
        ST_FIN   = 4'd7,
        ST_DONE  = 4'd8
    } boot_state_e;

    // Standard serial-flash READ opcode
    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    // Reverse byte order: the peripheral returns the first received byte in
    // [31:24], while the image is stored little-endian in RAM.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_boot_loader.sv
// Boot loader: copies NWORDS words from SPI flash into RAM through the SPI
// peripheral's Wishbone slave port, then raises a sticky boot_done_o.
module spi_boot_loader
    import spi_boot_pkg::*;
#(
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter int unsigned NWORDS     = 256,
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter logic [3:0]  PRESC      = 4'd1,
    parameter logic        CPOL       = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_in,
    output logic        spi_cyc_o,
    output logic        spi_stb_o,
    output logic        spi_we_o,
    input  logic        spi_ack_i,
    output logic [31:0] spi_dat_o,
    input  logic [31:0] spi_dat_i,
    output logic [3:0]  presc_o,
    output logic [1:0]  size_o,
    output logic        cpol_o,
    output logic        auto_cs_o,
    input  logic        rdy_i,
    output logic        flash_cs_no,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    input  logic        mem_ack_i,
    output logic        boot_done_o
);

    // Word index must be able to hold NWORDS itself; keep at least one bit.
    localparam int IDX_W = (NWORDS < 32'd2) ? 1 : $clog2(NWORDS + 32'd1);

    // READ opcode goes out first (bits [7:0]), then the address MSB first.
    localparam logic [31:0] CMD_WORD = {FLASH_ADDR[7:0], FLASH_ADDR[15:8],
                                        FLASH_ADDR[23:16], FLASH_CMD_READ};

    boot_state_e      state_q;
    logic             first_q;      // first cycle of a wait state: rdy_i not yet valid
    logic             spi_cyc_q;
    logic             spi_we_q;
    logic [31:0]      spi_dat_q;
    logic             cs_n_q;
    logic             mem_cyc_q;
    logic [31:0]      mem_adr_q;
    logic [31:0]      mem_dat_q;
    logic             done_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_word_s;

    // The word being written is the final one of the image
    assign last_word_s = ((32'(idx_q) + 32'd1) >= NWORDS);

    // Boot sequencer: state, word index and all registered bus outputs
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            first_q   <= 1'b0;
            spi_cyc_q <= 1'b0;
            spi_we_q  <= 1'b0;
            spi_dat_q <= 32'h0000_0000;
            cs_n_q    <= 1'b1;
            mem_cyc_q <= 1'b0;
            mem_adr_q <= 32'h0000_0000;
            mem_dat_q <= 32'h0000_0000;
            done_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rdy_i) begin
                        state_q   <= ST_CMD;
                        cs_n_q    <= 1'b0;
                        spi_cyc_q <= 1'b1;
                        spi_we_q  <= 1'b1;
                        spi_dat_q <= CMD_WORD;
                    end
                end
                ST_CMD: begin
                    spi_cyc_q <= 1'b0;
                    spi_we_q  <= 1'b0;
                    first_q   <= 1'b1;
                    state_q   <= ST_CWAIT;
                end
                ST_CWAIT: begin
                    first_q <= 1'b0;
                    if (!first_q && rdy_i) begin
                        if (NWORDS == 32'd0) begin
                            cs_n_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            spi_cyc_q <= 1'b1;
                            spi_we_q  <= 1'b1;
                            spi_dat_q <= 32'h0000_0000;
                            state_q   <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    spi_cyc_q <= 1'b0;
                    spi_we_q  <= 1'b0;
                    first_q   <= 1'b1;
                    state_q   <= ST_XWAIT;
                end
                ST_XWAIT: begin
                    first_q <= 1'b0;
                    if (!first_q && rdy_i) begin
                        spi_cyc_q <= 1'b1;
                        spi_we_q  <= 1'b0;
                        state_q   <= ST_RD;
                    end
                end
                ST_RD: begin
                    // Ack is combinational on the slave, so this normally takes one cycle
                    if (spi_ack_i) begin
                        spi_cyc_q <= 1'b0;
                        mem_cyc_q <= 1'b1;
                        mem_adr_q <= RAM_BASE + 32'({idx_q, 2'b00});
                        mem_dat_q <= bswap32(spi_dat_i);
                        state_q   <= ST_MWR;
                    end
                end
                ST_MWR: begin
                    if (mem_ack_i) begin
                        mem_cyc_q <= 1'b0;
                        idx_q     <= idx_q + IDX_W'(1);
                        if (last_word_s) begin
                            cs_n_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            // Peripheral stays idle after a read, so rdy_i seen
                            // in XWAIT still holds for this strobe.
                            spi_cyc_q <= 1'b1;
                            spi_we_q  <= 1'b1;
                            spi_dat_q <= 32'h0000_0000;
                            state_q   <= ST_XFER;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    spi_cyc_q <= 1'b0;
                    spi_we_q  <= 1'b0;
                    mem_cyc_q <= 1'b0;
                    cs_n_q    <= 1'b1;
                end
            endcase
        end
    end

    assign spi_cyc_o   = spi_cyc_q;
    assign spi_stb_o   = spi_cyc_q;
    assign spi_we_o    = spi_we_q;
    assign spi_dat_o   = spi_dat_q;
    assign presc_o     = PRESC;
    assign size_o      = 2'd3;
    assign cpol_o      = CPOL;
    assign auto_cs_o   = 1'b0;
    assign flash_cs_no = cs_n_q;
    assign mem_cyc_o   = mem_cyc_q;
    assign mem_stb_o   = mem_cyc_q;
    assign mem_we_o    = mem_cyc_q;
    assign mem_sel_o   = 4'hF;
    assign mem_adr_o   = mem_adr_q;
    assign mem_dat_o   = mem_dat_q;
    assign boot_done_o = done_q;

endmodule
